// File: rtl/plic_gateway.sv
// Per-source PLIC interrupt gateway: level/edge capture, claim/complete handshake, pending/busy vectors.
// Optional `PLIC_GATEWAY_SYNC_EN adds a 2-flop synchronizer on i_irq for asynchronous device lines.
module plic_gateway #(
    parameter int unsigned      SRC_N     = 8,
    parameter int unsigned      ID_W      = $clog2(SRC_N + 1),
    parameter int unsigned      CNT_W     = 2,
    parameter logic [SRC_N-1:0] EDGE_MASK = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [SRC_N-1:0] i_irq,
    input  logic             i_claim,
    input  logic [ID_W-1:0]  i_claim_id,
    input  logic             i_complete,
    input  logic [ID_W-1:0]  i_complete_id,
    output logic [SRC_N-1:0] o_pending,
    output logic [SRC_N-1:0] o_busy
);

    localparam logic [1:0]       ST_IDLE    = 2'd0;
    localparam logic [1:0]       ST_PENDING = 2'd1;
    localparam logic [1:0]       ST_CLAIMED = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [SRC_N-1:0] irq_s;

`ifdef PLIC_GATEWAY_SYNC_EN
    logic [SRC_N-1:0] sync_q1;
    logic [SRC_N-1:0] sync_q2;

    // Two-stage synchronizer for lines not generated in the clk domain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= i_irq;
            sync_q2 <= sync_q1;
        end
    end

    assign irq_s = sync_q2;
`else
    assign irq_s = i_irq;
`endif

    logic [SRC_N-1:0][1:0]       state_q;
    logic [SRC_N-1:0][1:0]       state_d;
    logic [SRC_N-1:0][CNT_W-1:0] cnt_q;
    logic [SRC_N-1:0][CNT_W-1:0] cnt_d;
    logic [SRC_N-1:0]            prev_q;
    logic [SRC_N-1:0]            pending_d;
    logic [SRC_N-1:0]            busy_d;
    logic [SRC_N-1:0]            rise_c;
    logic [SRC_N-1:0]            dec_c;
    logic [SRC_N-1:0]            claim_hit_c;
    logic [SRC_N-1:0]            complete_hit_c;

    // Per-source next state, edge counter update and output decode
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pending_d      = '0;
        busy_d         = '0;
        rise_c         = '0;
        dec_c          = '0;
        claim_hit_c    = '0;
        complete_hit_c = '0;
        for (int k = 0; k < int'(SRC_N); k++) begin
            rise_c[k]         = EDGE_MASK[k] & irq_s[k] & ~prev_q[k];
            claim_hit_c[k]    = i_claim && (i_claim_id == ID_W'(k + 1))
                                && (state_q[k] == ST_PENDING);
            complete_hit_c[k] = i_complete && (i_complete_id == ID_W'(k + 1))
                                && (state_q[k] == ST_CLAIMED);
            case (state_q[k])
                ST_IDLE: begin
                    if (EDGE_MASK[k]) begin
                        if (cnt_q[k] != '0) begin
                            state_d[k] = ST_PENDING;
                            dec_c[k]   = 1'b1;
                        end
                    end else if (irq_s[k]) begin
                        state_d[k] = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (claim_hit_c[k]) begin
                        state_d[k] = ST_CLAIMED;
                    end
                end
                ST_CLAIMED: begin
                    if (complete_hit_c[k]) begin
                        state_d[k] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[k] = ST_IDLE;
                end
            endcase
            // A simultaneous edge and consumption cancel; a saturated counter drops the edge
            if (rise_c[k] && !dec_c[k]) begin
                if (cnt_q[k] != CNT_MAX) begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end else if (dec_c[k] && !rise_c[k]) begin
                cnt_d[k] = cnt_q[k] - CNT_W'(1);
            end
            pending_d[k] = (state_d[k] == ST_PENDING);
            busy_d[k]    = (state_d[k] == ST_CLAIMED);
        end
    end

    // State, counters, edge history and registered output decode
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= {SRC_N{ST_IDLE}};
            cnt_q     <= '0;
            prev_q    <= '0;
            o_pending <= '0;
            o_busy    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= irq_s;
            o_pending <= pending_d;
            o_busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_plic_gateway.sv
// Self-checking bench for plic_gateway: table-driven scenarios with an expected-output queue.
module tb_plic_gateway;

    localparam int unsigned SRC_N = 8;
    localparam int unsigned ID_W  = 4;

    logic             clk;
    logic             rstn;
    logic [SRC_N-1:0] i_irq;
    logic             i_claim;
    logic [ID_W-1:0]  i_claim_id;
    logic             i_complete;
    logic [ID_W-1:0]  i_complete_id;
    logic [SRC_N-1:0] o_pending;
    logic [SRC_N-1:0] o_busy;

    typedef struct packed {
        logic [7:0] irq;
        logic       claim;
        logic [3:0] cid;
        logic       comp;
        logic [3:0] did;
        logic [7:0] ep;
        logic [7:0] eb;
    } row_t;

    typedef struct packed {
        logic [7:0] p;
        logic [7:0] b;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;

    plic_gateway #(
        .SRC_N    (SRC_N),
        .ID_W     (ID_W),
        .CNT_W    (2),
        .EDGE_MASK(8'h01)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_irq        (i_irq),
        .i_claim      (i_claim),
        .i_claim_id   (i_claim_id),
        .i_complete   (i_complete),
        .i_complete_id(i_complete_id),
        .o_pending    (o_pending),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic row_t r(input logic [7:0] irq, input logic claim, input logic [3:0] cid,
                               input logic comp, input logic [3:0] did,
                               input logic [7:0] ep, input logic [7:0] eb);
        row_t x;
        x.irq = irq; x.claim = claim; x.cid = cid; x.comp = comp; x.did = did;
        x.ep = ep; x.eb = eb;
        return x;
    endfunction

    task automatic drive(input row_t x);
        exp_t e;
        i_irq         = x.irq;
        i_claim       = x.claim;
        i_claim_id    = x.cid;
        i_complete    = x.comp;
        i_complete_id = x.did;
        e.p = x.ep;
        e.b = x.eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rstn = 1'b0; i_irq = '0; i_claim = 1'b0; i_claim_id = '0;
        i_complete = 1'b0; i_complete_id = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) rstn = 1'b1;
            e.p = 8'h00; e.b = 8'h00;
            sb.push_back(e);
            e = sb.pop_front();
            total++;
            if (o_pending !== e.p || o_busy !== e.b) begin
                bad++;
                $display("FAIL reset[%0d]: pending=%h busy=%h expected pending=%h busy=%h",
                         i, o_pending, o_busy, e.p, e.b);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_level();
        row_t rows[$];
        exp_t e;
        rows.push_back(r(8'h04, 0, 0, 0, 0, 8'h04, 8'h00));
        rows.push_back(r(8'h04, 0, 0, 0, 0, 8'h04, 8'h00));
        rows.push_back(r(8'h04, 1, 3, 0, 0, 8'h00, 8'h04));
        rows.push_back(r(8'h04, 0, 0, 0, 0, 8'h00, 8'h04));
        rows.push_back(r(8'h04, 0, 0, 1, 3, 8'h00, 8'h00));
        rows.push_back(r(8'h04, 0, 0, 0, 0, 8'h04, 8'h00));
        rows.push_back(r(8'h00, 0, 0, 0, 0, 8'h04, 8'h00));
        rows.push_back(r(8'h00, 1, 3, 0, 0, 8'h00, 8'h04));
        rows.push_back(r(8'h00, 0, 0, 1, 3, 8'h00, 8'h00));
        rows.push_back(r(8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            total++;
            if (o_pending !== e.p || o_busy !== e.b) begin
                bad++;
                $display("FAIL level[%0d]: pending=%h busy=%h expected pending=%h busy=%h",
                         i, o_pending, o_busy, e.p, e.b);
            end
        end
    endtask

    task automatic test_edge();
        row_t rows[$];
        exp_t e;
        rows.push_back(r(8'h01, 0, 0, 0, 0, 8'h00, 8'h00));
        rows.push_back(r(8'h01, 0, 0, 0, 0, 8'h01, 8'h00));
        rows.push_back(r(8'h00, 0, 0, 0, 0, 8'h01, 8'h00));
        rows.push_back(r(8'h00, 1, 1, 0, 0, 8'h00, 8'h01));
        for (int n = 0; n < 5; n++) begin
            rows.push_back(r(8'h01, 0, 0, 0, 0, 8'h00, 8'h01));
            rows.push_back(r(8'h00, 0, 0, 0, 0, 8'h00, 8'h01));
        end
        for (int n = 0; n < 3; n++) begin
            rows.push_back(r(8'h00, 0, 0, 1, 1, 8'h00, 8'h00));
            rows.push_back(r(8'h00, 0, 0, 0, 0, 8'h01, 8'h00));
            rows.push_back(r(8'h00, 1, 1, 0, 0, 8'h00, 8'h01));
        end
        rows.push_back(r(8'h00, 0, 0, 1, 1, 8'h00, 8'h00));
        rows.push_back(r(8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
        rows.push_back(r(8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            total++;
            if (o_pending !== e.p || o_busy !== e.b) begin
                bad++;
                $display("FAIL edge[%0d]: pending=%h busy=%h expected pending=%h busy=%h",
                         i, o_pending, o_busy, e.p, e.b);
            end
        end
    endtask

    task automatic test_invalid();
        row_t rows[$];
        exp_t e;
        rows.push_back(r(8'h04, 0, 0, 0, 0, 8'h04, 8'h00));
        rows.push_back(r(8'h00, 1, 0, 0, 0, 8'h04, 8'h00));
        rows.push_back(r(8'h00, 1, 9, 0, 0, 8'h04, 8'h00));
        rows.push_back(r(8'h00, 1, 11, 0, 0, 8'h04, 8'h00));
        rows.push_back(r(8'h00, 1, 2, 0, 0, 8'h04, 8'h00));
        rows.push_back(r(8'h00, 0, 0, 1, 3, 8'h04, 8'h00));
        rows.push_back(r(8'h00, 0, 0, 1, 0, 8'h04, 8'h00));
        rows.push_back(r(8'h00, 1, 3, 0, 0, 8'h00, 8'h04));
        rows.push_back(r(8'h00, 1, 3, 0, 0, 8'h00, 8'h04));
        rows.push_back(r(8'h00, 0, 0, 1, 2, 8'h00, 8'h04));
        rows.push_back(r(8'h00, 0, 0, 1, 11, 8'h00, 8'h04));
        rows.push_back(r(8'h00, 0, 0, 1, 3, 8'h00, 8'h00));
        rows.push_back(r(8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            total++;
            if (o_pending !== e.p || o_busy !== e.b) begin
                bad++;
                $display("FAIL invalid[%0d]: pending=%h busy=%h expected pending=%h busy=%h",
                         i, o_pending, o_busy, e.p, e.b);
            end
        end
    endtask

    task automatic test_same_cycle();
        row_t rows[$];
        exp_t e;
        rows.push_back(r(8'h12, 0, 0, 0, 0, 8'h12, 8'h00));
        rows.push_back(r(8'h00, 1, 5, 0, 0, 8'h02, 8'h10));
        rows.push_back(r(8'h00, 1, 2, 1, 5, 8'h00, 8'h02));
        rows.push_back(r(8'h00, 1, 2, 1, 2, 8'h00, 8'h00));
        rows.push_back(r(8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            total++;
            if (o_pending !== e.p || o_busy !== e.b) begin
                bad++;
                $display("FAIL same_cycle[%0d]: pending=%h busy=%h expected pending=%h busy=%h",
                         i, o_pending, o_busy, e.p, e.b);
            end
        end
    endtask

    task automatic test_reset_mid();
        row_t rows[$];
        exp_t e;
        rows.push_back(r(8'h29, 0, 0, 0, 0, 8'h28, 8'h00));
        rows.push_back(r(8'h29, 0, 0, 0, 0, 8'h29, 8'h00));
        rows.push_back(r(8'h08, 1, 6, 0, 0, 8'h09, 8'h20));
        rows.push_back(r(8'h09, 0, 0, 0, 0, 8'h09, 8'h20));
        rows.push_back(r(8'h08, 0, 0, 0, 0, 8'h09, 8'h20));
        rows.push_back(r(8'h09, 0, 0, 0, 0, 8'h09, 8'h20));
        rows.push_back(r(8'h08, 0, 0, 0, 0, 8'h09, 8'h20));
        rows.push_back(r(8'h08, 0, 0, 0, 0, 8'h08, 8'h00));
        rows.push_back(r(8'h08, 0, 0, 0, 0, 8'h08, 8'h00));
        rows.push_back(r(8'h08, 0, 0, 0, 0, 8'h08, 8'h00));
        rows.push_back(r(8'h08, 1, 4, 0, 0, 8'h00, 8'h08));
        rows.push_back(r(8'h00, 0, 0, 1, 4, 8'h00, 8'h00));
        rows.push_back(r(8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
        foreach (rows[i]) begin
            if (i == 7) begin
                // Asynchronous reset between clock edges, held across one edge
                #2 rstn = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    #1;
                    e.p = 8'h00; e.b = 8'h00;
                    sb.push_back(e);
                    e = sb.pop_front();
                    total++;
                    if (o_pending !== e.p || o_busy !== e.b) begin
                        bad++;
                        $display("FAIL reset_mid_async[%0d]: pending=%h busy=%h expected pending=%h busy=%h",
                                 j, o_pending, o_busy, e.p, e.b);
                    end
                    if (j == 0) @(posedge clk);
                end
                rstn = 1'b1;
            end
            drive(rows[i]);
            e = sb.pop_front();
            total++;
            if (o_pending !== e.p || o_busy !== e.b) begin
                bad++;
                $display("FAIL reset_mid[%0d]: pending=%h busy=%h expected pending=%h busy=%h",
                         i, o_pending, o_busy, e.p, e.b);
            end
        end
    endtask

    task automatic test_sync_latency();
        row_t rows[$];
        exp_t e;
        rows.push_back(r(8'h04, 0, 0, 0, 0, 8'h00, 8'h00));
        rows.push_back(r(8'h04, 0, 0, 0, 0, 8'h00, 8'h00));
        rows.push_back(r(8'h04, 0, 0, 0, 0, 8'h04, 8'h00));
        rows.push_back(r(8'h00, 1, 3, 0, 0, 8'h00, 8'h04));
        rows.push_back(r(8'h00, 0, 0, 0, 0, 8'h00, 8'h04));
        rows.push_back(r(8'h00, 0, 0, 1, 3, 8'h00, 8'h00));
        rows.push_back(r(8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
        rows.push_back(r(8'h01, 0, 0, 0, 0, 8'h00, 8'h00));
        rows.push_back(r(8'h01, 0, 0, 0, 0, 8'h00, 8'h00));
        rows.push_back(r(8'h01, 0, 0, 0, 0, 8'h00, 8'h00));
        rows.push_back(r(8'h00, 0, 0, 0, 0, 8'h01, 8'h00));
        rows.push_back(r(8'h00, 1, 1, 0, 0, 8'h00, 8'h01));
        rows.push_back(r(8'h00, 0, 0, 1, 1, 8'h00, 8'h00));
        rows.push_back(r(8'h00, 0, 0, 0, 0, 8'h00, 8'h00));
        foreach (rows[i]) begin
            drive(rows[i]);
            e = sb.pop_front();
            total++;
            if (o_pending !== e.p || o_busy !== e.b) begin
                bad++;
                $display("FAIL sync_latency[%0d]: pending=%h busy=%h expected pending=%h busy=%h",
                         i, o_pending, o_busy, e.p, e.b);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
`ifdef PLIC_GATEWAY_SYNC_EN
        test_sync_latency();
`else
        test_level();
        test_edge();
        test_invalid();
        test_same_cycle();
        test_reset_mid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/plic_gateway.md
# plic_gateway

Per-source interrupt gateway for the platform-level interrupt controller. It turns raw level-triggered or edge-triggered interrupt lines into a clean pending vector. Each pending bit is held until a hart claims that source, and the source is then blocked until the hart completes it. The pending vector is the producer side of the priority selection path: downstream logic masks it, pairs it with priorities, and reduces it to the winning source ID, which is later returned to this block as claim and complete requests.

## Interface
Parameters:
- `SRC_N`, default 8: number of interrupt sources; the valid source IDs are 1..`SRC_N`, and ID 0 means "no interrupt".
- `ID_W`, default `$clog2(SRC_N+1)`: width of a source ID.
- `CNT_W`, default 2: width of each edge counter; the counter saturates at 2^`CNT_W`-1.
- `EDGE_MASK`, default all zeros, width `SRC_N`: bit k-1 set makes source k edge-triggered; clear makes it level-triggered.

Ports:
- `clk` input 1: clock; the only clock.
- `rstn` input 1: asynchronous, active-low reset.
- `i_irq` input `SRC_N`: raw interrupt lines; bit k-1 is source k.
- `i_claim` input 1: claim strobe; one request per cycle.
- `i_claim_id` input `ID_W`: ID being claimed.
- `i_complete` input 1: complete strobe.
- `i_complete_id` input `ID_W`: ID being completed.
- `o_pending` output `SRC_N`: bit k-1 high while source k is in PENDING.
- `o_busy` output `SRC_N`: bit k-1 high while source k is in CLAIMED.

## Operation
- Each source runs its own FSM with states IDLE, PENDING and CLAIMED. Reset puts every source in IDLE.
- Outputs are registered decodes of the state: `o_pending` = (state==PENDING), `o_busy` = (state==CLAIMED).
- Level source transitions:
  - IDLE & irq -> PENDING.
  - PENDING & claim hit -> CLAIMED.
  - CLAIMED & complete hit -> IDLE.
  - irq is ignored outside IDLE. Dropping irq while PENDING does not clear pending.
- Edge source:
  - A prev-irq register detects rising edges; it resets to 0.
  - Each rising edge increments `cnt` in any state. `cnt` saturates, and further edges are lost silently.
  - IDLE & cnt!=0 -> PENDING, and `cnt` decrements.
  - PENDING -> CLAIMED and CLAIMED -> IDLE follow the same claim/complete rules as a level source.
  - An increment and a decrement in the same cycle leave `cnt` unchanged.
- Claim hit: `i_claim` & `i_claim_id`==k & state==PENDING. Complete hit: `i_complete` & `i_complete_id`==k & state==CLAIMED.
- Ignored requests, with no state change:
  - a claim of a source that is not PENDING;
  - a complete of a source that is not CLAIMED;
  - ID 0;
  - any ID greater than `SRC_N`.
- A claim and a complete in the same cycle are both applied. This holds even for the same ID, because the two hits are mutually exclusive by state.
- Reset asserted mid-operation discards all pending, claimed and counted interrupts.

## Timing
- Level: irq sampled high at edge t gives `o_pending` high after t (cycle t+1).
- Edge: a rising edge sampled at t increments `cnt` at t. PENDING follows at t+1 and `cnt` returns to 0.
- A claim at edge t drops `o_pending` and raises `o_busy` in cycle t+1.
- A complete at edge t gives IDLE at t+1. If the level irq is still high, or `cnt`!=0, the source is PENDING again at t+2.
- A source therefore spends at least one cycle in IDLE between CLAIMED and PENDING.
- With `PLIC_GATEWAY_SYNC_EN` enabled, every irq-related latency above grows by 2 cycles.
- Reset values: `o_pending`=0, `o_busy`=0, every `cnt`=0, every prev-irq register=0.

## Configuration
- `PLIC_GATEWAY_SYNC_EN` defined:
  - `i_irq` passes through a 2-flop synchronizer, reset to 0, before edge detection and FSM sampling.
  - Use it for asynchronous device lines.
- `PLIC_GATEWAY_SYNC_EN` undefined:
  - `i_irq` is sampled directly.
  - It must be synchronous to `clk`.

## Test plan
- Level source 3 (`SRC_N`=8, macro off): raise `i_irq[2]` -> `o_pending`=8'h04 next cycle. Claim ID 3 -> `o_pending`=0, `o_busy`=8'h04. Complete with irq still high -> IDLE for one cycle, then `o_pending`=8'h04.
- Edge source 1 with `CNT_W`=2: 5 rising edges while CLAIMED -> `cnt`=3 (saturated). Three complete/claim rounds each re-pend the source, and the fourth complete leaves it IDLE.
- Invalid requests: claim ID 0, claim ID 9, claim ID 2 while IDLE, complete ID 3 while PENDING -> no change to `o_pending` or `o_busy`.
- Same cycle: claim ID 2 (PENDING) plus complete ID 5 (CLAIMED) -> source 2 goes to CLAIMED and source 5 to IDLE in the same cycle.
- Reset mid-operation: sources 1/4 PENDING, source 6 CLAIMED, an edge counter at 2; assert `rstn`=0 asynchronously -> all outputs are 0 immediately, and after release nothing pends unless irq is still high.
- Macro on: irq rises at edge t -> `o_pending` is high in cycle t+3.
